// File: rtl/issue_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_stage (plus issue_select_pkg)
// Description : Round-robin issue select. Each FU port picks one ready
//               reservation-station entry of its type per cycle. The chosen
//               entry is granted combinationally and becomes a registered
//               packet on that FU's issue port one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================

package issue_select_pkg;

    // Reservation-station entry contents carried to the functional units.
    typedef struct packed {
        logic        br_tag;   // issued under an unresolved branch
        logic [5:0]  rob_idx;  // reorder-buffer slot
        logic [31:0] data;     // operand / immediate payload
    } rs_entry_t;

endpackage

module issue_select_stage
    import issue_select_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int FU_NUM   = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     flush,
    input  logic [RS_DEPTH-1:0]                      rs_ready_i,
    input  logic [RS_DEPTH-1:0][$clog2(FU_NUM)-1:0]  rs_fu_type_i,
    input  rs_entry_t [RS_DEPTH-1:0]                 rs_entries_i,
    input  logic                                     clear_wrong_instr_i,
    input  logic                                     clear_br_tag_i,
    input  logic [FU_NUM-1:0]                        fu_ready_i,
    output logic [RS_DEPTH-1:0]                      issue_o,
    output logic [FU_NUM-1:0]                        issue_valid_o,
    output rs_entry_t [FU_NUM-1:0]                   issue_pkt_o
);

    localparam int c_fu_w  = $clog2(FU_NUM);
    localparam int c_ptr_w = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    // The branch unit is the highest FU type code; branch work is never
    // squashed by clear_wrong_instr_i because it resolves the tag itself.
    localparam logic [c_fu_w-1:0] c_fu_branch = c_fu_w'(FU_NUM - 1);

    // Grants are only possible outside reset and flush.
    logic w_active;
    assign w_active = reset & ~flush;

    // Entries that a wrong-path squash would kill.
    logic [RS_DEPTH-1:0] w_rs_squash;

    generate
        for (genvar i = 0; i < RS_DEPTH; i++) begin : g_rs_squash
            assign w_rs_squash[i] = rs_entries_i[i].br_tag &
                                    (rs_fu_type_i[i] != c_fu_branch);
        end
    endgenerate

    // Per-FU grant vectors, merged into issue_o below.
    logic [FU_NUM-1:0][RS_DEPTH-1:0] w_grant;

    generate
        for (genvar f = 0; f < FU_NUM; f++) begin : g_fu

            // A held packet on the branch port is never squashable.
            localparam bit c_is_branch = (f == FU_NUM - 1);

            logic [RS_DEPTH-1:0] w_cand;
            logic [RS_DEPTH-1:0] w_sel;
            logic                w_any;
            logic [c_ptr_w-1:0]  w_idx;
            logic [c_ptr_w-1:0]  w_next_ptr;
            logic                w_can_accept;
            logic                w_pkt_squash;

            logic                r_valid;
            rs_entry_t           r_pkt;
            logic [c_ptr_w-1:0]  r_rr_ptr;

            for (genvar i = 0; i < RS_DEPTH; i++) begin : g_cand
                assign w_cand[i] = rs_ready_i[i] &
                                   (rs_fu_type_i[i] == c_fu_w'(f)) &
                                   ~(clear_wrong_instr_i & w_rs_squash[i]);
            end

            assign w_can_accept = ~r_valid | fu_ready_i[f];
            assign w_pkt_squash = r_pkt.br_tag & ~c_is_branch;

            // Round-robin search: first candidate at or after r_rr_ptr, wrapping.
            always_comb begin
                int pos;
                int nxt;
                pos        = 0;
                nxt        = 0;
                w_sel      = '0;
                w_any      = 1'b0;
                w_idx      = '0;
                w_next_ptr = '0;
                if (w_active && w_can_accept) begin
                    for (int k = 0; k < RS_DEPTH; k++) begin
                        pos = int'(r_rr_ptr) + k;
                        if (pos >= RS_DEPTH) begin
                            pos = pos - RS_DEPTH;
                        end
                        if (!w_any && w_cand[c_ptr_w'(pos)]) begin
                            w_any               = 1'b1;
                            w_sel[c_ptr_w'(pos)] = 1'b1;
                            w_idx               = c_ptr_w'(pos);
                            nxt                 = pos + 1;
                            if (nxt >= RS_DEPTH) begin
                                nxt = 0;
                            end
                            w_next_ptr          = c_ptr_w'(nxt);
                        end
                    end
                end
            end

            assign w_grant[f] = w_sel;

            // Issue slot: reset > flush > new grant > squash > drain > hold.
            // A new grant is always non-squashable, so loading it while a squash
            // is active never lets wrong-path work through.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_valid  <= 1'b0;
                    r_pkt    <= '0;
                    r_rr_ptr <= '0;
                end else if (flush) begin
                    r_valid  <= 1'b0;
                    r_rr_ptr <= '0;
                end else if (w_any) begin
                    r_valid  <= 1'b1;
                    r_pkt    <= rs_entries_i[w_idx];
                    r_rr_ptr <= w_next_ptr;
                end else if (r_valid && clear_wrong_instr_i && w_pkt_squash) begin
                    r_valid  <= 1'b0;
                end else if (r_valid && fu_ready_i[f]) begin
                    r_valid  <= 1'b0;
                end else if (r_valid && clear_br_tag_i && !clear_wrong_instr_i) begin
                    r_pkt.br_tag <= 1'b0;
                end
            end

            assign issue_valid_o[f] = r_valid;
            assign issue_pkt_o[f]   = r_pkt;
        end
    endgenerate

    // Each entry has exactly one FU type, so the per-FU grants never overlap.
    always_comb begin
        issue_o = '0;
        for (int f = 0; f < FU_NUM; f++) begin
            issue_o = issue_o | w_grant[f];
        end
    end

endmodule

`default_nettype wire

// File: doc/issue_select_stage.md
ISSUE_SELECT_STAGE -- requirements
Module: issue_select_stage

Interface
REQ-001 The block SHALL have parameter RS_DEPTH, default 8: number of RS entries observed.
REQ-002 The block SHALL have parameter FU_NUM, default 4: number of FU issue ports, one per FU type code 0..FU_NUM-1.
REQ-003 The block SHALL have the following ports, clock and reset first:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  full pipeline flush.
- rs_ready_i  in  RS_DEPTH  per-entry ready (valid, both sources ready).
- rs_fu_type_i  in  RS_DEPTH x $clog2(FU_NUM)  per-entry FU type.
- rs_entries_i  in  RS_DEPTH x rs_entry_t  per-entry contents.
- clear_wrong_instr_i  in  1  squash of branch-tagged non-branch work.
- clear_br_tag_i  in  1  branch resolved correctly; clear tags.
- fu_ready_i  in  FU_NUM  FU f accepts a packet this cycle.
- issue_o  out  RS_DEPTH  combinational grant to RS entries; the entry frees at the next edge.
- issue_valid_o  out  FU_NUM  registered packet valid per FU.
- issue_pkt_o  out  FU_NUM x rs_entry_t  registered packet per FU.

Function
REQ-004 For each FU f, the candidate set SHALL be entries i with rs_ready_i[i]=1 and rs_fu_type_i[i]=f, excluding squashable entries while clear_wrong_instr_i=1.
- Squashable: br_tag=1 and fu_type != FU_BRANCH.
REQ-005 Slot f SHALL be able to accept when issue_valid_o[f]=0 or fu_ready_i[f]=1.
REQ-006 When slot f can accept, flush=0 and reset=1, the block SHALL grant exactly one candidate for FU f.
- The granted candidate is the first index at or after rr_ptr[f], searching upward with wrap-around modulo RS_DEPTH.
- The block SHALL grant no candidate for FU f otherwise.
REQ-007 issue_o SHALL be the OR of all per-FU grants; each entry SHALL receive at most one grant per cycle; issue_o SHALL be 0 when flush=1 or reset=0.
REQ-008 On a grant to entry g for FU f, rr_ptr[f] SHALL become (g+1) mod RS_DEPTH at the next edge; rr_ptr[f] SHALL otherwise hold.
REQ-009 On a grant, the next edge SHALL load issue_pkt_o[f] with rs_entries_i[g] and set issue_valid_o[f]=1; latency from grant to valid is 1 cycle.
REQ-010 A valid packet with fu_ready_i[f]=0 SHALL hold, unchanged, in issue_pkt_o[f] and issue_valid_o[f].
REQ-011 A valid packet with fu_ready_i[f]=1 and no new grant SHALL clear issue_valid_o[f] at the next edge; with a new grant, the new packet SHALL replace it back-to-back.
REQ-012 clear_wrong_instr_i=1 SHALL clear, at the next edge, issue_valid_o[f] for every held packet that is squashable (same definition as REQ-004); non-squashable packets SHALL be unaffected.
REQ-013 clear_br_tag_i=1 SHALL clear the br_tag field of every held valid packet at the next edge.
- If clear_wrong_instr_i and clear_br_tag_i are both 1, clear_wrong_instr_i SHALL take priority.
REQ-014 flush=1 SHALL, at the next edge, clear all issue_valid_o and reset all rr_ptr to 0.
REQ-015 issue_pkt_o contents while issue_valid_o[f]=0 SHALL be don't-care; the bench SHALL NOT check them.

Reset
REQ-016 With reset=0 at a rising edge, the block SHALL set issue_valid_o=0, issue_pkt_o=0 and every rr_ptr[f]=0.
- issue_o SHALL be 0 combinationally throughout reset=0.
REQ-017 Reset asserted mid-operation SHALL discard held packets without any handshake.
REQ-018 Reset SHALL take priority over flush, which SHALL take priority over clear_wrong_instr_i, which SHALL take priority over grant and hold.

Verification
REQ-019 Rotation: RS_DEPTH=8; entries 1, 3, 6 ready with fu_type 0; fu_ready_i[0]=1.
- Required: issue_o grants 1, 3, 6, 1 on successive cycles.
- Required: issue_valid_o[0]=1 from the cycle after the first grant, carrying entries 1, 3, 6 in order.
REQ-020 Back-pressure: packet held on FU 2 with fu_ready_i[2]=0 for 3 cycles and entry 4 ready on type 2.
- Required: no grant to entry 4 and issue_pkt_o[2] unchanged for 3 cycles.
- Required: entry 4 granted in the cycle fu_ready_i[2]=1.
REQ-021 Parallel ports: entry 0 type 0 and entry 5 type 1 ready in the same cycle.
- Required: issue_o=8'b0010_0001, and both FU valids set next cycle.
REQ-022 Squash: FU 0 holds br_tag=1 ALU packet; FU 3 holds br_tag=1 branch packet; clear_wrong_instr_i=1 for one cycle.
- Required: issue_valid_o[0]=0 and issue_valid_o[3]=1 next cycle.
REQ-023 Flush/reset: rr_ptr[0]=5 and all slots valid; flush=1, then separately reset=0.
- Required: each clears all valids and sets rr_ptr[0]=0; issue_o=0 during the event.
